// File: rtl/kinase_seq_pkg.sv
// Shared types and valve-word constants for the kinase-activity bus sequencer.
// Valve encoding: 1 = pressurized (closed).
package kinase_seq_pkg;

    localparam int NC = 13;
    localparam int NS = 4;
    localparam int NP = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GUARD    = 3'd1,
        FILL_A   = 3'd2,
        FILL_B   = 3'd3,
        MIX      = 3'd4,
        INCUBATE = 3'd5,
        FLUSH    = 3'd6
    } phase_t;

    typedef struct packed {
        logic [NC-1:0] c;
        logic [NS-1:0] s;
        logic [NP-1:0] p;
    } valve_t;

    localparam valve_t VW_CLOSED = {13'h1FFF, 4'hF, 5'h1F};
    localparam valve_t VW_FILL_A = {13'h1FFC, 4'hE, 5'h1F};
    localparam valve_t VW_FILL_B = {13'h1FF3, 4'hD, 5'h1F};
    localparam valve_t VW_MIX    = {13'h1F0F, 4'hF, 5'h1F};
    localparam valve_t VW_FLUSH  = {13'h00FF, 4'h0, 5'h00};

    // MIX pump bits are overridden by the live peristaltic pattern.
    function automatic valve_t valve_word(input phase_t ph);
        case (ph)
            FILL_A:  return VW_FILL_A;
            FILL_B:  return VW_FILL_B;
            MIX:     return VW_MIX;
            FLUSH:   return VW_FLUSH;
            default: return VW_CLOSED;
        endcase
    endfunction

    // Step k closes p[k] and p[(k+1)%5].
    function automatic logic [NP-1:0] pump_pat(input logic [2:0] k);
        case (k)
            3'd0:    return 5'b00011;
            3'd1:    return 5'b00110;
            3'd2:    return 5'b01100;
            3'd3:    return 5'b11000;
            default: return 5'b10001;
        endcase
    endfunction

endpackage

// File: rtl/kinase_valve_sequencer_pump.sv
// Peristaltic step generator: step counter plus the 5-bit pump pattern.
// p_pat is the pattern for the *next* cycle so the top can register it with the phase.
module pump_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    output logic [NP-1:0] p_pat,
    output logic          rot_tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [2:0]    k_q, k_nxt;
    logic          step_end;

    assign step_end = (cnt_q == LAST);
    // Raw wrap indicator; the top only honours it while in MIX.
    assign rot_tick = step_end && (k_q == 3'd4);

    always_comb begin
        cnt_nxt = cnt_q;
        k_nxt   = k_q;
        if (clear) begin
            cnt_nxt = '0;
            k_nxt   = 3'd0;
        end else if (en) begin
            if (step_end) begin
                cnt_nxt = '0;
                k_nxt   = (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    assign p_pat = pump_pat(k_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            k_q   <= 3'd0;
        end else begin
            cnt_q <= cnt_nxt;
            k_q   <= k_nxt;
        end
    end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Drives the shared kinase-activity valve bus through one assay:
// fill A, fill B, peristaltic mix, incubate, flush, with all-closed guards between phases.
module kinase_valve_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int STEP_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int FLUSH_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cfg_fill,
    input  logic [7:0]  cfg_mix_rot,
    input  logic [23:0] cfg_incubate,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [2:0]  phase,
    output logic [12:0] c,
    output logic [3:0]  s,
    output logic [4:0]  p
);

    phase_t        phase_q, phase_nxt;
    phase_t        gnext_q, gnext_nxt;
    logic          abort_q;
    logic [23:0]   tmr_q, tmr_load;
    logic [7:0]    rot_q;
    logic [15:0]   fill_q;
    logic [7:0]    mixr_q;
    logic [23:0]   inc_q;
    logic          enter, accept, abort_go, tmr_end;
    logic          rot_tick;
    logic [NP-1:0] p_pat;
    valve_t        vw_nxt, vw_q;
    logic          busy_nxt, done_nxt, aborted_nxt;
    logic          busy_q, done_q, aborted_q;

    assign tmr_end = (tmr_q == 24'd1);
    assign accept  = (phase_q == IDLE) && start && !abort;
    // Once the abort flush is under way, or the run is in its final guard, abort has no effect.
    assign abort_go = abort && (phase_q != IDLE) && !abort_q
                      && !((phase_q == GUARD) && (gnext_q == IDLE));

    pump_phase_gen #(.STEP_CYCLES(STEP_CYCLES)) u_pump (
        .clk      (clk),
        .rst      (rst),
        .en       (phase_q == MIX),
        .clear    (phase_nxt != MIX),
        .p_pat    (p_pat),
        .rot_tick (rot_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= IDLE;
            gnext_q <= IDLE;
            abort_q <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            gnext_q <= gnext_nxt;
            if (abort_go)
                abort_q <= 1'b1;
            else if (phase_nxt == IDLE)
                abort_q <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        phase_nxt = phase_q;
        gnext_nxt = gnext_q;
        enter     = 1'b0;
        case (phase_q)
            IDLE: if (accept) begin
                phase_nxt = GUARD; gnext_nxt = FILL_A; enter = 1'b1;
            end
            GUARD: if (tmr_end) begin
                phase_nxt = gnext_q; enter = 1'b1;
            end
            FILL_A: if (tmr_end) begin
                phase_nxt = GUARD; gnext_nxt = FILL_B; enter = 1'b1;
            end
            FILL_B: if (tmr_end) begin
                phase_nxt = GUARD; enter = 1'b1;
                gnext_nxt = (mixr_q != 8'd0) ? MIX : (inc_q != 24'd0) ? INCUBATE : FLUSH;
            end
            MIX: if (rot_tick && rot_q == 8'd1) begin
                phase_nxt = GUARD; enter = 1'b1;
                gnext_nxt = (inc_q != 24'd0) ? INCUBATE : FLUSH;
            end
            INCUBATE: if (tmr_end) begin
                phase_nxt = GUARD; gnext_nxt = FLUSH; enter = 1'b1;
            end
            FLUSH: if (tmr_end) begin
                phase_nxt = GUARD; gnext_nxt = IDLE; enter = 1'b1;
            end
            default: begin
                phase_nxt = IDLE; gnext_nxt = IDLE; enter = 1'b1;
            end
        endcase
        if (abort_go) begin
            phase_nxt = GUARD; gnext_nxt = FLUSH; enter = 1'b1;
        end
    end

    // Output logic (next-cycle values, registered below)
    always_comb begin
        vw_nxt = valve_word(phase_nxt);
        if (phase_nxt == MIX)
            vw_nxt.p = p_pat;
        busy_nxt    = (phase_nxt != IDLE);
        done_nxt    = (phase_q == GUARD) && tmr_end && (gnext_q == IDLE) && !abort_q;
        aborted_nxt = (phase_q == GUARD) && tmr_end && (gnext_q == IDLE) && abort_q;
    end

    // MIX length is governed by the rotation counter, so its timer load is unused.
    always_comb begin
        case (phase_nxt)
            GUARD:          tmr_load = 24'(GUARD_CYCLES);
            FILL_A, FILL_B: tmr_load = (fill_q == 16'd0) ? 24'd1 : {8'd0, fill_q};
            INCUBATE:       tmr_load = inc_q;
            FLUSH:          tmr_load = 24'(FLUSH_CYCLES);
            default:        tmr_load = 24'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q  <= 24'd0;
            rot_q  <= 8'd0;
            fill_q <= 16'd0;
            mixr_q <= 8'd0;
            inc_q  <= 24'd0;
        end else begin
            if (enter)
                tmr_q <= tmr_load;
            else if (tmr_q != 24'd0)
                tmr_q <= tmr_q - 24'd1;
            if (phase_q != MIX)
                rot_q <= mixr_q;
            else if (rot_tick)
                rot_q <= rot_q - 8'd1;
            if (accept) begin
                fill_q <= cfg_fill;
                mixr_q <= cfg_mix_rot;
                inc_q  <= cfg_incubate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vw_q      <= VW_CLOSED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            vw_q      <= vw_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    assign phase   = phase_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign c       = vw_q.c;
    assign s       = vw_q.s;
    assign p       = vw_q.p;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Directed bench for kinase_valve_sequencer with STEP=2, GUARD=2, FLUSH=4.
module tb_kinase_valve_sequencer;
    import kinase_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] cfg_fill;
    logic [7:0]  cfg_mix_rot;
    logic [23:0] cfg_incubate;
    logic        busy, done, aborted;
    logic [2:0]  phase;
    logic [12:0] c;
    logic [3:0]  s;
    logic [4:0]  p;

    int tests = 0;
    int fails = 0;

    logic [2:0]  run_ph[$];
    int          run_len[$];
    logic [21:0] run_vw[$];
    logic [4:0]  mix_p[$];
    int          done_cnt, abort_cnt, done_at;
    bit          reached_idle;

    always #5 clk = ~clk;

    kinase_valve_sequencer #(.STEP_CYCLES(2), .GUARD_CYCLES(2), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_fill(cfg_fill), .cfg_mix_rot(cfg_mix_rot), .cfg_incubate(cfg_incubate),
        .busy(busy), .done(done), .aborted(aborted), .phase(phase),
        .c(c), .s(s), .p(p)
    );

    localparam logic [21:0] W_CLOSED = {13'h1FFF, 4'hF, 5'h1F};
    localparam logic [21:0] W_FLUSH  = {13'h00FF, 4'h0, 5'h00};

    function automatic logic [21:0] exp_vw(input logic [2:0] ph);
        case (ph)
            3'd2:    return {13'h1FFC, 4'hE, 5'h1F};
            3'd3:    return {13'h1FF3, 4'hD, 5'h1F};
            3'd4:    return {13'h1F0F, 4'hF, 5'h03};
            3'd6:    return W_FLUSH;
            default: return W_CLOSED;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] f, input logic [7:0] r, input logic [23:0] i);
        cfg_fill = f; cfg_mix_rot = r; cfg_incubate = i;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Record phase runs from the current cycle until IDLE, plus two trailing cycles.
    task automatic capture(input int budget);
        int k;
        run_ph.delete(); run_len.delete(); run_vw.delete(); mix_p.delete();
        done_cnt = 0; abort_cnt = 0; done_at = -1; reached_idle = 0;
        for (int n = 0; n < budget && !reached_idle; n++) begin
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (aborted) abort_cnt++;
            if (phase == 3'd0) begin
                reached_idle = 1;
            end else begin
                k = run_ph.size();
                if (k != 0 && run_ph[k-1] == phase) begin
                    run_len[k-1] = run_len[k-1] + 1;
                end else begin
                    run_ph.push_back(phase);
                    run_len.push_back(1);
                    run_vw.push_back({c, s, p});
                end
                if (phase == 3'd4) mix_p.push_back(p);
            end
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_fill = '0; cfg_mix_rot = '0; cfg_incubate = '0;
        repeat (3) tick();
        tests++; if ({c, s, p} !== W_CLOSED) begin fails++; $display("FAIL reset_valves got %h exp %h", {c, s, p}, W_CLOSED); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d exp 0", phase); end
        tests++; if ({done, aborted} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b exp 00", {done, aborted}); end
        rst = 1'b0;
        tick();
        tests++; if (phase !== 3'd0) begin fails++; $display("FAIL post_reset_phase got %0d exp 0", phase); end
    endtask

    task automatic test_full_run();
        logic [2:0] eph[11] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd1, 3'd4, 3'd1, 3'd5, 3'd1, 3'd6, 3'd1};
        int         elen[11] = '{2, 3, 2, 3, 2, 10, 2, 5, 2, 4, 2};
        logic [4:0] ep[10] = '{5'h03, 5'h03, 5'h06, 5'h06, 5'h0C, 5'h0C, 5'h18, 5'h18, 5'h11, 5'h11};
        start_run(16'd3, 8'd1, 24'd5);
        tests++; if (busy !== 1'b1 || phase !== 3'd1) begin fails++; $display("FAIL full_accept got busy=%b phase=%0d exp busy=1 phase=1", busy, phase); end
        // changed cfg after accept must not affect this run
        cfg_fill = 16'd7; cfg_mix_rot = 8'd3; cfg_incubate = 24'd9;
        capture(100);
        tests++; if (run_ph.size() != 11) begin fails++; $display("FAIL full_nruns got %0d exp 11", run_ph.size()); end
        for (int i = 0; i < 11; i++) if (i < run_ph.size()) begin
            tests++; if (run_ph[i] !== eph[i] || run_len[i] != elen[i]) begin
                fails++; $display("FAIL full_run%0d got ph=%0d len=%0d exp ph=%0d len=%0d", i, run_ph[i], run_len[i], eph[i], elen[i]);
            end
            tests++; if (run_vw[i] !== exp_vw(eph[i])) begin
                fails++; $display("FAIL full_valves%0d got %h exp %h", i, run_vw[i], exp_vw(eph[i]));
            end
        end
        tests++; if (mix_p.size() != 10) begin fails++; $display("FAIL full_mix_len got %0d exp 10", mix_p.size()); end
        for (int i = 0; i < 10; i++) if (i < mix_p.size()) begin
            tests++; if (mix_p[i] !== ep[i]) begin fails++; $display("FAIL full_pump%0d got %h exp %h", i, mix_p[i], ep[i]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done_count got %0d exp 1", done_cnt); end
        tests++; if (done_at != 37) begin fails++; $display("FAIL full_done_at got %0d exp 37", done_at); end
        tests++; if (abort_cnt != 0) begin fails++; $display("FAIL full_aborted got %0d exp 0", abort_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_skip();
        logic [2:0] eph[7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd1, 3'd6, 3'd1};
        int         elen[7] = '{2, 1, 2, 1, 2, 4, 2};
        start_run(16'd0, 8'd0, 24'd0);
        capture(60);
        tests++; if (run_ph.size() != 7) begin fails++; $display("FAIL skip_nruns got %0d exp 7", run_ph.size()); end
        for (int i = 0; i < 7; i++) if (i < run_ph.size()) begin
            tests++; if (run_ph[i] !== eph[i] || run_len[i] != elen[i]) begin
                fails++; $display("FAIL skip_run%0d got ph=%0d len=%0d exp ph=%0d len=%0d", i, run_ph[i], run_len[i], eph[i], elen[i]);
            end
        end
        tests++; if (done_at != 14 || done_cnt != 1) begin fails++; $display("FAIL skip_done got at=%0d cnt=%0d exp at=14 cnt=1", done_at, done_cnt); end
    endtask

    task automatic test_abort();
        int pre_done = 0;
        logic [2:0] eph[3] = '{3'd1, 3'd6, 3'd1};
        int         elen[3] = '{2, 4, 2};
        start_run(16'd1, 8'd2, 24'd3);
        for (int n = 0; n < 40 && phase != 3'd4; n++) begin
            if (done) pre_done++;
            tick();
        end
        tests++; if (phase !== 3'd4) begin fails++; $display("FAIL abort_reach_mix got %0d exp 4", phase); end
        repeat (4) tick();
        tests++; if (p !== 5'h0C) begin fails++; $display("FAIL abort_step2 got %h exp 0c", p); end
        // abort is held high through the flush, final guard and idle
        abort = 1'b1;
        tick();
        capture(40);
        abort = 1'b0;
        tests++; if (run_ph.size() != 3) begin fails++; $display("FAIL abort_nruns got %0d exp 3", run_ph.size()); end
        for (int i = 0; i < 3; i++) if (i < run_ph.size()) begin
            tests++; if (run_ph[i] !== eph[i] || run_len[i] != elen[i]) begin
                fails++; $display("FAIL abort_run%0d got ph=%0d len=%0d exp ph=%0d len=%0d", i, run_ph[i], run_len[i], eph[i], elen[i]);
            end
            tests++; if (run_vw[i] !== exp_vw(eph[i])) begin
                fails++; $display("FAIL abort_valves%0d got %h exp %h", i, run_vw[i], exp_vw(eph[i]));
            end
        end
        tests++; if (abort_cnt != 1) begin fails++; $display("FAIL abort_pulse got %0d exp 1", abort_cnt); end
        tests++; if (done_cnt + pre_done != 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", done_cnt + pre_done); end
        tests++; if (phase !== 3'd0) begin fails++; $display("FAIL abort_idle got %0d exp 0", phase); end
    endtask

    task automatic test_ignore_start();
        logic [2:0] eph[6] = '{3'd2, 3'd1, 3'd3, 3'd1, 3'd6, 3'd1};
        int         elen[6] = '{1, 2, 3, 2, 4, 2};
        cfg_fill = 16'd3; cfg_mix_rot = 8'd0; cfg_incubate = 24'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        tests++; if (phase !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL both_high got phase=%0d busy=%b exp 0/0", phase, busy); end
        tick();
        start = 1'b0; abort = 1'b0;
        tests++; if (phase !== 3'd0) begin fails++; $display("FAIL both_high_hold got %0d exp 0", phase); end
        start_run(16'd3, 8'd0, 24'd0);
        repeat (3) tick();
        tests++; if (phase !== 3'd2) begin fails++; $display("FAIL busy_start_fill got %0d exp 2", phase); end
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(60);
        tests++; if (run_ph.size() != 6) begin fails++; $display("FAIL busy_start_nruns got %0d exp 6", run_ph.size()); end
        for (int i = 0; i < 6; i++) if (i < run_ph.size()) begin
            tests++; if (run_ph[i] !== eph[i] || run_len[i] != elen[i]) begin
                fails++; $display("FAIL busy_start_run%0d got ph=%0d len=%0d exp ph=%0d len=%0d", i, run_ph[i], run_len[i], eph[i], elen[i]);
            end
        end
        tests++; if (done_at != 14 || done_cnt != 1) begin fails++; $display("FAIL busy_start_done got at=%0d cnt=%0d exp at=14 cnt=1", done_at, done_cnt); end
    endtask

    task automatic test_reset_mid();
        start_run(16'd2, 8'd0, 24'd6);
        repeat (12) tick();
        tests++; if (phase !== 3'd5) begin fails++; $display("FAIL rstmid_incubate got %0d exp 5", phase); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (phase !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_state got phase=%0d busy=%b exp 0/0", phase, busy); end
        tests++; if ({c, s, p} !== W_CLOSED) begin fails++; $display("FAIL rstmid_valves got %h exp %h", {c, s, p}, W_CLOSED); end
        tests++; if ({done, aborted} !== 2'b00) begin fails++; $display("FAIL rstmid_pulses got %b exp 00", {done, aborted}); end
        start_run(16'd1, 8'd0, 24'd0);
        capture(60);
        tests++; if (run_ph.size() != 7) begin fails++; $display("FAIL rstmid_rerun_nruns got %0d exp 7", run_ph.size()); end
        tests++; if (done_at != 14 || done_cnt != 1) begin fails++; $display("FAIL rstmid_rerun_done got at=%0d cnt=%0d exp at=14 cnt=1", done_at, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_skip();
        test_abort();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
